// File: rtl/stopwatch_core.sv
// MM:SS BCD stopwatch core: edge-detects divider levels into ticks; run/pause/adjust FSM.
// Optional STOPWATCH_BLINK_EN blanks the adjusted field while clk_2hz is high.
module stopwatch_core #(
  parameter int MAX_MIN = 59
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clk_1hz,
  input  logic       clk_2hz,
  input  logic       pause,
  input  logic       adj,
  input  logic       sel,
  output logic [3:0] min_tens,
  output logic [3:0] min_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_ones,
  output logic       running,
  output logic       wrap
);

  localparam logic [3:0] MAX_MT = 4'(MAX_MIN / 10);
  localparam logic [3:0] MAX_MO = 4'(MAX_MIN % 10);

  typedef enum logic [1:0] {
    ST_PAUSE = 2'd0,
    ST_RUN   = 2'd1,
    ST_ADJ   = 2'd2
  } state_t;

  state_t     state_q, state_d, eff_state;
  logic       run_q, run_d;
  logic       p1_q, p2_q;
  logic       tick1, tick2;
  logic [7:0] sec_q, sec_d;
  logic [7:0] min_q, min_d;
  logic       wrap_q, wrap_d;

  // {tens, ones}: seconds roll 59 -> 00
  function automatic logic [7:0] sec_inc(input logic [7:0] s);
    if (s[3:0] == 4'd9) begin
      if (s[7:4] == 4'd5) return 8'd0;
      return {s[7:4] + 4'd1, 4'd0};
    end
    return {s[7:4], s[3:0] + 4'd1};
  endfunction

  function automatic logic [7:0] min_inc(input logic [7:0] m);
    if (m == {MAX_MT, MAX_MO}) return 8'd0;
    if (m[3:0] == 4'd9) return {m[7:4] + 4'd1, 4'd0};
    return {m[7:4], m[3:0] + 4'd1};
  endfunction

  assign tick1 = clk_1hz & ~p1_q;
  assign tick2 = clk_2hz & ~p2_q;

  always_comb begin
    state_d   = state_q;
    run_d     = run_q;
    sec_d     = sec_q;
    min_d     = min_q;
    wrap_d    = 1'b0;
    // Cycle adj drops: behave as the remembered state straight away
    eff_state = state_q;
    if (state_q == ST_ADJ) eff_state = run_q ? ST_RUN : ST_PAUSE;

    if (adj) begin
      state_d = ST_ADJ;
      if (state_q != ST_ADJ) run_d = (state_q == ST_RUN);
      if (tick2) begin
        if (sel) sec_d = sec_inc(sec_q);
        else     min_d = min_inc(min_q);
      end
    end else begin
      state_d = eff_state;
      case (eff_state)
        ST_PAUSE: begin
          if (pause) state_d = ST_RUN;
        end
        ST_RUN: begin
          if (tick1) begin
            sec_d = sec_inc(sec_q);
            if (sec_q == 8'h59) begin
              min_d  = min_inc(min_q);
              wrap_d = (min_q == {MAX_MT, MAX_MO});
            end
          end
          if (pause) state_d = ST_PAUSE;
        end
        default: state_d = ST_PAUSE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      // Load live levels so an input already high at release gives no tick
      p1_q    <= clk_1hz;
      p2_q    <= clk_2hz;
      state_q <= ST_PAUSE;
      run_q   <= 1'b0;
      sec_q   <= 8'd0;
      min_q   <= 8'd0;
      wrap_q  <= 1'b0;
    end else begin
      p1_q    <= clk_1hz;
      p2_q    <= clk_2hz;
      state_q <= state_d;
      run_q   <= run_d;
      sec_q   <= sec_d;
      min_q   <= min_d;
      wrap_q  <= wrap_d;
    end
  end

  assign running = (state_q == ST_RUN);
  assign wrap    = wrap_q;

`ifdef STOPWATCH_BLINK_EN
  logic blank_min_q, blank_min_d;
  logic blank_sec_q, blank_sec_d;

  assign blank_min_d = (state_d == ST_ADJ) && clk_2hz && !sel;
  assign blank_sec_d = (state_d == ST_ADJ) && clk_2hz && sel;

  always_ff @(posedge clk) begin
    if (rst) begin
      blank_min_q <= 1'b0;
      blank_sec_q <= 1'b0;
    end else begin
      blank_min_q <= blank_min_d;
      blank_sec_q <= blank_sec_d;
    end
  end

  assign min_tens = blank_min_q ? 4'hF : min_q[7:4];
  assign min_ones = blank_min_q ? 4'hF : min_q[3:0];
  assign sec_tens = blank_sec_q ? 4'hF : sec_q[7:4];
  assign sec_ones = blank_sec_q ? 4'hF : sec_q[3:0];
`else
  assign min_tens = min_q[7:4];
  assign min_ones = min_q[3:0];
  assign sec_tens = sec_q[7:4];
  assign sec_ones = sec_q[3:0];
`endif

endmodule

// File: tb/tb_stopwatch_core.sv
// Directed bench for stopwatch_core: hand-computed MM:SS values after each stimulus step.
module tb_stopwatch_core;

  logic       clk = 1'b0;
  logic       rst, clk_1hz, clk_2hz, pause, adj, sel;
  logic [3:0] min_tens, min_ones, sec_tens, sec_ones;
  logic       running, wrap;
  int         n_checks = 0;
  int         n_fail   = 0;

  stopwatch_core #(.MAX_MIN(59)) dut (
    .clk      (clk),
    .rst      (rst),
    .clk_1hz  (clk_1hz),
    .clk_2hz  (clk_2hz),
    .pause    (pause),
    .adj      (adj),
    .sel      (sel),
    .min_tens (min_tens),
    .min_ones (min_ones),
    .sec_tens (sec_tens),
    .sec_ones (sec_ones),
    .running  (running),
    .wrap     (wrap)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] digits();
    return {min_tens, min_ones, sec_tens, sec_ones};
  endfunction

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse1(input int n);
    repeat (n) begin
      clk_1hz = 1'b1; cyc(1);
      clk_1hz = 1'b0; cyc(1);
    end
  endtask

  task automatic pulse2(input int n);
    repeat (n) begin
      clk_2hz = 1'b1; cyc(1);
      clk_2hz = 1'b0; cyc(1);
    end
  endtask

  task automatic pause_pulse();
    pause = 1'b1; cyc(1);
    pause = 1'b0;
  endtask

  initial begin
    rst = 1'b1; clk_1hz = 1'b1; clk_2hz = 1'b0; pause = 1'b0; adj = 1'b0; sel = 1'b0;
    cyc(3);
    rst = 1'b0;
    cyc(3);
    check("reset_digits", digits(), 16'h0000);
    check("reset_running", 16'(running), 16'h0);
    check("reset_wrap", 16'(wrap), 16'h0);
    clk_1hz = 1'b0; cyc(1);
    check("no_tick_after_release", digits(), 16'h0000);

    // Run 61 seconds, then pause and confirm ticks ignored
    pause_pulse();
    check("run_running", 16'(running), 16'h1);
    pulse1(61);
    check("run_61", digits(), 16'h0101);
    pause_pulse();
    check("paused_running", 16'(running), 16'h0);
    pulse1(5);
    check("paused_ignore", digits(), 16'h0101);

    // Preload 59:58 from PAUSE
    adj = 1'b1; sel = 1'b0;
    pulse2(58);
    sel = 1'b1;
    pulse2(57);
    check("preload", digits(), 16'h5958);
    adj = 1'b0; cyc(1);
    check("adj_restore_pause", 16'(running), 16'h0);
    pause_pulse();
    pulse1(1);
    check("run_5959", digits(), 16'h5959);
    check("no_wrap_yet", 16'(wrap), 16'h0);
    clk_1hz = 1'b1; cyc(1);
    check("wrap_digits", digits(), 16'h0000);
    check("wrap_pulse", 16'(wrap), 16'h1);
    clk_1hz = 1'b0; cyc(1);
    check("wrap_one_cycle", 16'(wrap), 16'h0);

    // pause coincident with tick: counted, then paused
    clk_1hz = 1'b1; pause = 1'b1; cyc(1);
    clk_1hz = 1'b0; pause = 1'b0;
    check("pause_tick_digits", digits(), 16'h0001);
    check("pause_tick_state", 16'(running), 16'h0);
    cyc(1);
    pulse1(1);
    check("pause_tick_after", digits(), 16'h0001);

    // RUN, then adj rising with tick1: tick dropped
    pause_pulse();
    check("run_again", 16'(running), 16'h1);
    adj = 1'b1; sel = 1'b1; clk_1hz = 1'b1; cyc(1);
    clk_1hz = 1'b0; cyc(1);
    check("adj_drops_tick", digits(), 16'h0001);
    check("adj_not_running", 16'(running), 16'h0);
    pulse1(2);
    check("adj_ignore_tick1", digits(), 16'h0001);
    pause_pulse();
    pulse2(57);
    check("adj_sec_58", digits(), 16'h0058);
    pulse2(3);
    check("adj_sec_wrap", digits(), 16'h0001);
    check("adj_no_wrap", 16'(wrap), 16'h0);
    sel = 1'b0;
    pulse2(2);
    check("adj_min", digits(), 16'h0201);

    // Blanking of the selected field while clk_2hz is high
    clk_2hz = 1'b1; cyc(1);
`ifdef STOPWATCH_BLINK_EN
    check("blink_high", digits(), 16'hFF01);
`else
    check("no_blink_high", digits(), 16'h0301);
`endif
    clk_2hz = 1'b0; cyc(1);
    check("blink_low", digits(), 16'h0301);

    // Set 12:34, drop adj, RUN restored (pause pulse in adjust ignored)
    pulse2(9);
    sel = 1'b1;
    pulse2(33);
    adj = 1'b0; cyc(1);
    check("restore_digits", digits(), 16'h1234);
    check("restore_run", 16'(running), 16'h1);

    // Reset mid-run with coincident tick
    rst = 1'b1; clk_1hz = 1'b1; cyc(1);
    check("rst_digits", digits(), 16'h0000);
    check("rst_state", 16'(running), 16'h0);
    rst = 1'b0; clk_1hz = 1'b0; cyc(1);
    pulse1(2);
    check("rst_paused", digits(), 16'h0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/stopwatch_core.md
# stopwatch_core

Time-keeping core of the stopwatch. It consumes the divided clock levels produced by the clock divider (`clk_1hz`, `clk_2hz`) as free-running toggle signals in the `clk` domain. It edge-detects them into single-cycle ticks and maintains an MM:SS BCD count with run/pause and field-adjust modes. Its digit outputs feed the display driver.

## Interface
- `MAX_MIN`, default 59: highest minute value before the wrap to 0 (must be ≤ 99).
- `clk` input 1: system clock (100 MHz); all logic on posedge.
- `rst` input 1: reset, synchronous and active-high.
- `clk_1hz` input 1: divider output level; each rising transition is one count tick.
- `clk_2hz` input 1: divider output level; each rising transition is one adjust tick.
- `pause` input 1: single-cycle pulse (already debounced); toggles run/pause.
- `adj` input 1: level; high selects adjust mode.
- `sel` input 1: adjust field select; 0 = minutes, 1 = seconds.
- `min_tens`, `min_ones`, `sec_tens`, `sec_ones` output 4 each: BCD digits (4'hF = blank code).
- `running` output 1: high in RUN state.
- `wrap` output 1: one-cycle pulse when the count wraps from MAX_MIN:59 to 00:00.

## Operation
- Edge detect: registers `p1` and `p2` hold the previous `clk_1hz` and `clk_2hz` levels. `tick1 = clk_1hz & ~p1` and `tick2 = clk_2hz & ~p2`.
- During reset, `p1` and `p2` load the current input levels. An input already high at reset release therefore produces no tick.
- States:
  - PAUSE (reset state).
  - RUN.
  - ADJUST. This is entered whenever `adj`=1, overrides both other states, and remembers the prior RUN/PAUSE state in `run_q`.
- PAUSE: `pause` pulse goes to RUN. Ticks are ignored.
- RUN: `pause` pulse goes to PAUSE.
  - `tick1` increments seconds.
  - `sec_ones` wraps 9→0 and carries into `sec_tens`.
  - `sec_tens` wraps 5→0 and carries into minutes.
  - Minutes count 0..MAX_MIN in BCD and wrap to 0.
  - At full wrap (MAX_MIN:59 → 00:00), `wrap` pulses.
- `pause` and `tick1` in the same cycle while in RUN: the tick is counted, then the state goes to PAUSE.
- ADJUST: `tick1` is ignored. `tick2` increments the selected field only, with no carry into the other field.
  - Seconds wrap 59→00.
  - Minutes wrap MAX_MIN→00.
  - `wrap` never pulses in ADJUST.
- In ADJUST, `pause` pulses are ignored. On `adj` falling, return to the state held in `run_q`.
- Changing `sel` mid-adjust takes effect on the next `tick2`.
- Arithmetic: each digit is an independent 4-bit BCD counter. Digits never exceed 9, and tens-of-seconds never exceeds 5.
- `running` = (state==RUN). It is 0 in ADJUST and PAUSE.

## Timing
- Reset values:
  - All four digits 0.
  - `running`=0.
  - `wrap`=0.
  - State PAUSE.
  - `run_q`=0.
- A tick is recognised at the first posedge where the input is sampled 1 and the previous sample was 0. The digits show the new value immediately after that same edge (registered outputs, 1-cycle latency from the input's rising transition).
- `wrap` is asserted in the cycle after the wrapping edge, for exactly 1 cycle.
- `pause` takes effect at the sampling edge; `running` changes after that edge.
- `adj` is sampled each posedge. If `adj` rises in the same cycle as a `tick1`, the tick is dropped.
- Reset mid-operation: all state clears on the next posedge regardless of mode or pending ticks.
- Input ticks arrive at most every 25 M cycles. There is no back-to-back tick requirement, but logic must be correct for ticks on consecutive cycles.

## Configuration
- `STOPWATCH_BLINK_EN` defined:
  - In ADJUST, the two digits of the selected field output 4'hF while `clk_2hz` is sampled high, and their true values while it is low.
  - Unselected digits and non-ADJUST states are unaffected.
  - The blanking is registered, so output latency is unchanged.
- Undefined: digits always show their true values; no blanking logic is compiled.

## Test plan
- Reset with `clk_1hz`=1 held, release, no edges on either input → digits 00:00, `running`=0, no count.
- `pause` pulse, then 61 `clk_1hz` rising edges → 01:01 and `running`=1. Next `pause` pulse plus 5 further edges → still 01:01.
- Preload 59:58 via adjust, RUN, 2 `tick1` → 59:59 then 00:00 with a single-cycle `wrap`. Also cover `pause` coincident with `tick1`: the count advances and the state goes to PAUSE.
- `adj`=1, `sel`=1, from 00:58 apply 3 `clk_2hz` edges → 00:01 (no minute carry). Then `sel`=0 with 2 edges → 02:01. Drop `adj` → prior RUN/PAUSE state restored.
- `rst` pulse while RUN at 12:34 → 00:00 and PAUSE on the next edge. A tick coincident with `rst` is not counted.
- With `STOPWATCH_BLINK_EN` in ADJUST, `sel`=0 → `min_*`=4'hF while `clk_2hz`=1 and true values while 0; `sec_*` always true. Without the macro, no 4'hF ever appears.
